// File: rtl/cheshire_uart_rx_pkg.sv
// Shared types and helpers for the Cheshire UART console capture receiver.
package cheshire_uart_rx_pkg;

  localparam int unsigned DataBits = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Divisors below the floor cannot place a usable mid-bit sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] min_div);
    return (div < min_div) ? min_div : div;
  endfunction

endpackage

// File: rtl/cheshire_uart_rx_capture_fifo.sv
// Byte FIFO for the UART capture path: registered write, flush has priority,
// and a push into a full FIFO is accepted when a pop happens in the same cycle.
module cheshire_uart_rx_capture_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth):0]     usage_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW-1:0] PtrOne   = 1;
  localparam logic [AddrW:0]   UsageOne = 1;

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   usage_q;
  logic             do_push, do_pop;

  assign empty_o = (usage_q == '0);
  assign full_o  = (usage_q == (AddrW+1)'(Depth));
  assign usage_o = usage_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Gate the head so the stream reads zero while empty (storage is not reset).
  assign data_o = empty_o ? '0 : mem[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (do_push && !do_pop)      usage_q <= usage_q + UsageOne;
      else if (do_pop && !do_push) usage_q <= usage_q - UsageOne;
    end
  end

  // NOTE: storage has no reset; only pointers and occupancy define its contents.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cheshire_uart_rx_capture.sv
// 8N1 UART receiver with mid-bit sampling, runtime divisor and a byte FIFO,
// used to capture the SoC console stream in simulation and on FPGA.
module cheshire_uart_rx_capture
  import cheshire_uart_rx_pkg::*;
#(
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned MinDiv    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [15:0]                  baud_div_i,
  input  logic                         uart_rx_i,
  input  logic                         clear_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic [$clog2(FifoDepth):0]   fill_o
);

  localparam logic [15:0] MinDivW = 16'(MinDiv);

  logic [1:0]          sync_q;
  logic                rx_s, rx_q, rx_fall;
  rx_state_e           state_q, state_d;
  logic [15:0]         div_q, div_d, div_clamped;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                tick, push, pop, full;
  logic                frame_err_q, frame_err_d, overflow_q, empty;

  // Two-flop synchronizer plus delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
      rx_q   <= sync_q[1];
    end
  end

  assign rx_s        = sync_q[1];
  assign rx_fall     = rx_q && !rx_s;
  assign tick        = (cnt_q == '0);
  assign div_clamped = clamp_div(baud_div_i, MinDivW);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q - 16'd1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (rx_fall) begin
          div_d   = div_clamped;
          cnt_d   = (div_clamped >> 1) - 16'd1;
          state_d = START;
        end
      end
      START: if (tick) begin
        cnt_d = div_q - 16'd1;
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: if (tick) begin
        cnt_d   = div_q - 16'd1;
        shift_d = {rx_s, shift_q[DataBits-1:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'(DataBits - 1)) state_d = STOP;
      end
      STOP: if (tick) begin
        cnt_d = div_q - 16'd1;
        if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_d = cnt_q;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear abandons the frame; a still-low line needs a fresh falling edge.
    if (clear_i) begin
      state_d     = IDLE;
      push        = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  assign pop = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        overflow_q <= 1'b0;
    else if (clear_i)                   overflow_q <= 1'b0;
    else if (push && full && !pop)      overflow_q <= 1'b1;
  end

  cheshire_uart_rx_capture_fifo #(
    .Depth (FifoDepth),
    .Width (DataBits)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (data_o),
    .empty_o (empty),
    .full_o  (full),
    .usage_o (fill_o)
  );

  assign valid_o     = !empty;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_cheshire_uart_rx_capture.sv
// Randomized scoreboard bench for the UART capture receiver: stimulus queues the
// bytes the line should deliver, a negedge monitor checks every popped beat.
module tb_cheshire_uart_rx_capture;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd16;
  logic        uart_rx = 1'b1;
  logic        clear = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  data;
  logic        valid, busy, frame_err, overflow;
  logic [4:0]  fill;

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0;
  int beats = 0, last_beat_cyc = 0, err_seen = 0, exp_err = 0;
  logic [7:0] last_beat_data = '0;
  logic [7:0] exp_q[$];

  cheshire_uart_rx_capture #(.FifoDepth(Depth), .MinDiv(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .baud_div_i  (baud_div),
    .uart_rx_i   (uart_rx),
    .clear_i     (clear),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .fill_o      (fill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat is consumed at the edge following a cycle with valid && ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (valid && ready) begin
        beats++;
        last_beat_cyc  = cyc;
        last_beat_data = data;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_beat: got 0x%0h expected no beat (t=%0t)", data, $time);
        end else begin
          check("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame, one symbol per bit_cyc clocks, LSB first.
  task automatic send_byte(input logic [7:0] b, input int bit_cyc, input logic stop_bit);
    uart_rx   = 1'b0;
    start_cyc = cyc;
    step(bit_cyc);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      step(bit_cyc);
    end
    uart_rx = stop_bit;
    step(bit_cyc);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || valid) && n < 2000) begin
      step(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] b, b17;
    int div, n_bytes, b0;

    step(3);
    check("reset_outputs", {15'd0, valid, busy, frame_err, overflow, fill, data}, 0);
    rst_n = 1'b1;
    step(4);

    // Known pattern 0x55 at div 16: one beat roughly 9.5 bit times after the edge.
    ready = 1'b1;
    b0 = beats;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 16, 1'b1);
    step(32);
    check("beats_0x55", beats - b0, 1);
    check("latency_window", ((last_beat_cyc - start_cyc) >= 150 && (last_beat_cyc - start_cyc) <= 160), 1);

    // Random bytes at random divisors.
    for (int k = 0; k < 4; k++) begin
      div = $urandom_range(4, 24);
      b = 8'($urandom);
      baud_div = 16'(div);
      exp_q.push_back(b);
      send_byte(b, div, 1'b1);
      step(div * 2);
    end
    wait_drain("drain_random");
    check("no_flags_after_clean", {frame_err, overflow}, 0);
    check("frame_err_count_clean", err_seen, exp_err);

    // Short low glitch: START sample sees high again.
    baud_div = 16'd16;
    b0 = beats;
    uart_rx = 1'b0;
    step(2);
    uart_rx = 1'b1;
    step(3);
    check("glitch_busy_start", busy, 1);
    step(20);
    check("glitch_busy_drop", busy, 0);
    check("glitch_no_beat", beats - b0, 0);
    check("glitch_no_err", err_seen, exp_err);

    // Framing error followed by a break, then a normal frame.
    b0 = beats;
    send_byte(8'hA3, 16, 1'b0);
    exp_err++;
    step(40 * 16);
    check("frame_err_once", err_seen, exp_err);
    check("break_busy", busy, 1);
    check("break_no_beat", beats - b0, 0);
    uart_rx = 1'b1;
    step(32);
    check("break_released", busy, 0);
    exp_q.push_back(8'h0D);
    send_byte(8'h0D, 16, 1'b1);
    step(32);
    wait_drain("drain_0x0d");
    check("beats_after_break", beats - b0, 1);

    // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled.
    ready = 1'b0;
    baud_div = 16'd8;
    n_bytes = Depth + 1;
    for (int k = 0; k < n_bytes; k++) begin
      if (k < Depth) exp_q.push_back(8'(k));
      send_byte(8'(k), 8, 1'b1);
      step(4);
    end
    check("fill_full", fill, (n_bytes > Depth) ? Depth : n_bytes);
    check("overflow_set", overflow, (n_bytes > Depth) ? 1 : 0);
    check("head_stable_a", data, 8'h00);
    step(5);
    check("head_stable_b", data, 8'h00);
    ready = 1'b1;
    wait_drain("drain_overflow");
    check("fill_empty", fill, 0);
    check("overflow_sticky", overflow, 1);
    ready = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("overflow_cleared", overflow, 0);

    // Full FIFO, pop coinciding with the 17th push: accepted, no overflow.
    for (int k = 0; k < Depth; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 8, 1'b1);
      step(4);
    end
    check("refill_full", fill, Depth);
    b17 = 8'($urandom);
    exp_q.push_back(b17);
    baud_div = 16'd16;
    fork
      send_byte(b17, 16, 1'b1);
      begin
        // Write lands 3 + div/2 + 9*div edges after the start-bit edge.
        step(2 + 8 + 9 * 16);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
      end
    join
    step(16);
    check("full_pop_fill", fill, Depth);
    check("full_pop_no_overflow", overflow, 0);
    ready = 1'b1;
    wait_drain("drain_full_pop");
    check("last_drained_17th", last_beat_data, b17);

    // Divisor 2 is clamped to 4; back-to-back frames with no idle gap.
    baud_div = 16'd2;
    b0 = beats;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    send_byte(8'hFF, 4, 1'b1);
    send_byte(8'h00, 4, 1'b1);
    step(16);
    wait_drain("drain_b2b");
    check("beats_b2b", beats - b0, 2);

    // Reset mid-frame: partial byte lost, outputs return to zero.
    ready = 1'b0;
    uart_rx = 1'b0;
    step(20);
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #2;
    check("midframe_reset_outputs", {15'd0, valid, busy, frame_err, overflow, fill, data}, 0);
    uart_rx = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(100);
    check("after_reset_idle", {valid, busy, fill}, 0);
    check("frame_err_count_final", err_seen, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cheshire_uart_rx_capture.md
Name: cheshire_uart_rx_capture

Overview:
- Synthesizable UART receiver that consumes the SoC's serial output (uart_tx) directly downstream of the SoC top.
- Recovers 8N1 bytes by mid-bit sampling with a runtime clock divider.
- Buffers received bytes in a small FIFO and presents them on a valid/ready byte stream.
- Used by simulation fixtures and by FPGA debug capture to log SoC console output without a testbench-only model.

Parameters:
- FifoDepth, 16: byte FIFO entries; power of two, at least 2.
- MinDiv, 4: smallest accepted clocks-per-bit; any lower divisor value is clamped to MinDiv.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- baud_div_i  in  16  clock cycles per UART bit; latched at each start-bit detection
- uart_rx_i  in  1  serial line (idle high), asynchronous to clk_i
- clear_i  in  1  synchronous: flushes FIFO, clears sticky flags, forces IDLE
- data_o  out  8  head-of-FIFO byte
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer pops head when valid_o && ready_i
- busy_o  out  1  FSM not in IDLE
- frame_err_o  out  1  one-cycle pulse when the stop bit is sampled low
- overflow_o  out  1  sticky; byte dropped because FIFO was full
- fill_o  out  $clog2(FifoDepth)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, synchronizer flops set to 1.
- Input path: uart_rx_i passes a 2-flop synchronizer (rx_s). Edge detection uses rx_s and its 1-cycle delayed copy.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on a falling edge of rx_s, latch div = max(baud_div_i, MinDiv), load cnt = div/2 - 1 (integer division), go to START.
- cnt decrements every cycle. A "tick" is the cycle in which cnt == 0. On each tick, cnt reloads div-1.
- START tick: if rx_s == 1, treat as a glitch and return to IDLE with no flags. Otherwise clear bit index, go to DATA.
- DATA tick: shift rx_s into the byte, LSB first. After bit index 7, go to STOP.
- STOP tick:
  - rx_s == 1: push byte to FIFO, go to IDLE.
  - rx_s == 0: pulse frame_err_o, discard byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1 (covers break conditions), then go to IDLE. Falling edges seen in WAIT_IDLE are ignored.
- Latency: valid_o rises in the cycle after the STOP tick (registered FIFO write). Total delay is about 2 synchronizer cycles + 9.5 bit times after the start edge.
- Push/pop rules:
  - Push when full and no pop in the same cycle: byte dropped, overflow_o set.
  - Push when full with a pop in the same cycle: push accepted, fill unchanged, no overflow.
  - Pop when empty: ignored.
  - Simultaneous push and pop when not full: fill unchanged.
- data_o is stable while valid_o && !ready_i.
- overflow_o stays high until clear_i or reset.
- clear_i has priority over push and pop in the same cycle. The current frame is abandoned, the FSM goes to IDLE, and a line that is still low does not restart reception until the next falling edge.
- Changes to baud_div_i mid-frame have no effect until the next start bit.
- Back-to-back frames: a start edge arriving in the cycle the FSM returns to IDLE from STOP is detected (the edge detector is evaluated in IDLE in that same cycle).
- Reset mid-frame: immediate return to reset state; partial byte lost, no flags.

Decomposition:
- Shared package cheshire_uart_rx_pkg holds:
  - state enum rx_state_e (IDLE, START, DATA, STOP, WAIT_IDLE)
  - constant DataBits = 8
  - localparam function for the clamped divisor
- The FIFO is the one natural sub-module: instantiate common_cells fifo_v3 (FALL_THROUGH=0, DATA_WIDTH=8, DEPTH=FifoDepth).
- The synchronizer uses common_cells sync.
- FSM, counter and shift register are written inline.

Test Plan:
- div=16; send 0x55 8N1 with ready_i=1 -> exactly one valid_o beat with data_o=0x55 about 152 cycles after the start edge; frame_err_o and overflow_o stay 0.
- div=16; 20 ns low glitch on an idle line -> START tick samples 1, FSM back to IDLE, busy_o drops, no valid_o, no flags.
- div=16; send 0xA3 with the stop bit driven low, line held low 40 bit times -> one-cycle frame_err_o, no push, busy_o high until the line rises, then the next frame 0x0D is received correctly.
- FifoDepth=16; ready_i=0; send 17 bytes 0x00..0x10 -> fill_o=16, overflow_o=1; drain returns 0x00..0x0F in order; clear_i then clears overflow_o.
- FIFO full, ready_i=1 exactly in the cycle the 17th byte is pushed -> no overflow, fill_o stays 16, last byte drained is that 17th byte.
- baud_div_i=2 (clamped to 4); back-to-back frames 0xFF,0x00 with no idle gap -> both bytes received in order; then assert rst_ni low mid-frame -> all outputs 0 and the partial byte is lost.
